adsr_env: RTL



---
 rtl/adsr_env_pkg.sv | 16 +
 rtl/adsr_env_gate_sync.sv | 51 +++++
 rtl/adsr_env.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adsr_env_pkg.sv
// Shared definitions for the ADSR envelope generator.
// Holds the stage codes and the stage-code width. The RTL and the
// testbench both import this package so they agree on the encoding.
package adsr_env_pkg;

    localparam int STAGE_W = 3;

    typedef enum logic [STAGE_W-1:0] {
        ADSR_IDLE    = 3'd0,
        ADSR_ATTACK  = 3'd1,
        ADSR_DECAY   = 3'd2,
        ADSR_SUSTAIN = 3'd3,
        ADSR_RELEASE = 3'd4
    } stage_e;

endpackage

// File: rtl/adsr_env_gate_sync.sv
// Gate synchronizer and edge detector for the ADSR envelope.
//   clk, rst : envelope tick and asynchronous active-high reset
//   gate     : note-on level from the modulation domain (asynchronous)
//   rise     : one tick high when the synchronized gate goes 0 -> 1
//   fall     : one tick high when the synchronized gate goes 1 -> 0
// g1/g2 form the two-flop synchronizer and g3 is the edge register.
// A rise is only accepted once the gate has been seen low after reset.
// This way a gate held high through reset release does not start a note.
module adsr_env_gate_sync (
    input  logic clk,
    input  logic rst,
    input  logic gate,
    output logic rise,
    output logic fall
);

    logic       g1_r;
    logic       g2_r;
    logic       g3_r;
    logic [1:0] settle_r;
    logic       armed_r;

    // Synchronizer chain and edge register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1_r <= 1'b0;
            g2_r <= 1'b0;
            g3_r <= 1'b0;
        end else begin
            g1_r <= gate;
            g2_r <= g1_r;
            g3_r <= g2_r;
        end
    end

    // settle_r[1] marks that g2 carries a real post-reset sample of gate;
    // armed_r latches once that sample has been low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_r <= 2'b00;
            armed_r  <= 1'b0;
        end else begin
            settle_r <= {settle_r[0], 1'b1};
            armed_r  <= armed_r | (settle_r[1] & ~g2_r);
        end
    end

    assign rise = armed_r & g2_r & ~g3_r;
    assign fall = ~g2_r & g3_r;

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator, clocked by the slow envelope tick.
//   clk, rst     : envelope tick and asynchronous active-high reset
//   gate         : note-on level, asynchronous to clk
//   attack       : per-tick increment is attack+1
//   decay        : per-tick decrement is decay+1
//   sustain      : sustain level, sampled live every tick
//   release_rate : per-tick decrement is release_rate+1 (the bare word
//                  "release" is reserved in SystemVerilog)
//   env          : registered envelope value
//   stage        : registered stage code (see adsr_env_pkg)
//   active       : registered, high whenever stage is not IDLE
// Gate edges take priority over rate progression. On a tick where an edge
// changes the stage, env holds its value, so retrigger is legato.
module adsr_env
    import adsr_env_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gate,
    input  logic [RATE_W-1:0]  attack,
    input  logic [RATE_W-1:0]  decay,
    input  logic [WIDTH-1:0]   sustain,
    input  logic [RATE_W-1:0]  release_rate,
    output logic [WIDTH-1:0]   env,
    output logic [STAGE_W-1:0] stage,
    output logic               active
);

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   FULL_X = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    logic             rise_s;
    logic             fall_s;
    stage_e           stage_r;
    stage_e           stage_n_s;
    logic [WIDTH-1:0] env_r;
    logic [WIDTH-1:0] env_n_s;
    logic             active_r;

    logic [WIDTH-1:0] inc_s;
    logic [WIDTH-1:0] dec_s;
    logic [WIDTH-1:0] rel_s;
    logic [WIDTH:0]   att_sum_s;
    logic [WIDTH:0]   dec_floor_s;
    logic [WIDTH-1:0] dec_diff_s;
    logic [WIDTH-1:0] rel_diff_s;

    adsr_env_gate_sync u_gate_sync (
        .clk  (clk),
        .rst  (rst),
        .gate (gate),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Rate steps are at most 2^RATE_W, so they fit in WIDTH bits.
    assign inc_s = {{(WIDTH-RATE_W){1'b0}}, attack}       + ONE_W;
    assign dec_s = {{(WIDTH-RATE_W){1'b0}}, decay}        + ONE_W;
    assign rel_s = {{(WIDTH-RATE_W){1'b0}}, release_rate} + ONE_W;

    // The attack sum and the decay floor are widened by one bit so they
    // never wrap. The subtractions are only used when env exceeds the step.
    assign att_sum_s   = {1'b0, env_r} + {1'b0, inc_s};
    assign dec_floor_s = {1'b0, sustain} + {1'b0, dec_s};
    assign dec_diff_s  = env_r - dec_s;
    assign rel_diff_s  = env_r - rel_s;

    // Next-stage and next-envelope selection
    always_comb begin
        stage_n_s = stage_r;
        env_n_s   = env_r;
        if (rise_s) begin
            stage_n_s = ADSR_ATTACK;
        end else if (fall_s && (stage_r == ADSR_ATTACK ||
                                stage_r == ADSR_DECAY  ||
                                stage_r == ADSR_SUSTAIN)) begin
            stage_n_s = ADSR_RELEASE;
        end else begin
            case (stage_r)
                ADSR_IDLE: begin
                    env_n_s = ZERO_W;
                end
                ADSR_ATTACK: begin
                    if (att_sum_s >= FULL_X) begin
                        env_n_s   = {WIDTH{1'b1}};
                        stage_n_s = ADSR_DECAY;
                    end else begin
                        env_n_s = att_sum_s[WIDTH-1:0];
                    end
                end
                ADSR_DECAY: begin
                    if ({1'b0, env_r} <= dec_floor_s) begin
                        env_n_s   = sustain;
                        stage_n_s = ADSR_SUSTAIN;
                    end else begin
                        env_n_s = dec_diff_s;
                    end
                end
                ADSR_SUSTAIN: begin
                    env_n_s = sustain;
                end
                ADSR_RELEASE: begin
                    if (env_r <= rel_s) begin
                        env_n_s   = ZERO_W;
                        stage_n_s = ADSR_IDLE;
                    end else begin
                        env_n_s = rel_diff_s;
                    end
                end
                default: begin
                    env_n_s   = ZERO_W;
                    stage_n_s = ADSR_IDLE;
                end
            endcase
        end
    end

    // State, envelope and active flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r  <= ADSR_IDLE;
            env_r    <= ZERO_W;
            active_r <= 1'b0;
        end else begin
            stage_r  <= stage_n_s;
            env_r    <= env_n_s;
            active_r <= (stage_n_s != ADSR_IDLE);
        end
    end

    assign env    = env_r;
    assign stage  = stage_r;
    assign active = active_r;

endmodule
